// File: rtl/return_arbiter_if.sv
// rtl/return_arbiter_if.sv - completion request/return bus between bank ports and the returner
interface return_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 6
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_type;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*IDX_W-1:0]  req_index;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_type;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_index;
  logic                      out_ready;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  req_valid, req_type, req_data, req_index, out_ready,
    output req_ready, out_valid, out_type, out_data, out_index, grant_id
  );

  modport master (
    output req_valid, req_type, req_data, req_index, out_ready,
    input  req_ready, out_valid, out_type, out_data, out_index, grant_id
  );
endinterface

// File: rtl/return_arbiter.sv
// rtl/return_arbiter.sv - completion return arbiter with read priority and write starvation guard
module return_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 6,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  return_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;

  logic [ID_W-1:0]    rd_ptr, wr_ptr, ptr, gnt, gnt_inc;
  logic [3:0]         starve_cnt;
  logic [NUM_REQ-1:0] rd_cand, wr_cand, cand;
  logic               found, sel_wr, can_load, accept, write_force;
  logic               gnt_type;
  logic [DATA_W-1:0]  gnt_data;
  logic [IDX_W-1:0]   gnt_index;
  int unsigned        j;

  assign rd_cand     = bus.req_valid & ~bus.req_type;
  assign wr_cand     = bus.req_valid & bus.req_type;
  assign write_force = (starve_cnt >= 4'(STARVE_MAX));
  // Writes win only when forced or when no read is waiting.
  assign sel_wr      = (write_force && (|wr_cand)) || !(|rd_cand);
  assign cand        = sel_wr ? wr_cand : rd_cand;
  assign ptr         = sel_wr ? wr_ptr : rd_ptr;
  assign can_load    = (state == EMPTY) || bus.out_ready;
  assign accept      = can_load && found && !rst;
  assign gnt_inc     = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + 32'(k)) % 32'(NUM_REQ);
      if (!found && cand[ID_W'(j)]) begin
        found = 1'b1;
        gnt   = ID_W'(j);
      end
    end
  end

  always_comb begin
    gnt_type  = 1'b0;
    gnt_data  = '0;
    gnt_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        gnt_type  = bus.req_type[i];
        gnt_data  = bus.req_data[i*DATA_W +: DATA_W];
        gnt_index = bus.req_index[i*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (!accept && bus.out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_type  <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.grant_id  <= '0;
    end else if (accept) begin
      bus.out_type  <= gnt_type;
      bus.out_data  <= gnt_data;
      bus.out_index <= gnt_index;
      bus.grant_id  <= gnt;
    end
  end

  // A read granted while a write waits counts toward forcing the write through.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (accept) begin
      if (sel_wr) begin
        wr_ptr     <= gnt_inc;
        starve_cnt <= '0;
      end else begin
        rd_ptr <= gnt_inc;
        if ((|wr_cand) && (starve_cnt != 4'hF)) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_return_arbiter.sv
// tb/tb_return_arbiter.sv - self-checking bench for return_arbiter
module tb_return_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 6;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  return_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) bus();
  return_arbiter #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  bit            pv[N];
  bit            pt[N];
  logic [DW-1:0] pd[N];
  logic [IW-1:0] pi[N];
  bit            ordy;

  bit            m_ov, m_type;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  int            m_gid, m_rd, m_wr, m_starve;

  typedef struct {
    bit       rst;
    bit [3:0] valid;
    bit [3:0] typ;
    bit       ordy;
    bit [3:0] exp_ready;
    bit       exp_ov;
    int       exp_gid;
    bit       exp_type;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_pick(output bit ok, output int g, output bit w, output bit any_w);
    bit any_r;
    int p;
    any_r = 0; any_w = 0; ok = 0; g = 0;
    for (int i = 0; i < N; i++) begin
      if (pv[i] && !pt[i]) any_r = 1;
      if (pv[i] && pt[i])  any_w = 1;
    end
    w = (m_starve >= SM && any_w) || !any_r;
    p = w ? m_wr : m_rd;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (!ok && pv[c] && (pt[c] == w)) begin ok = 1; g = c; end
    end
    if (rst || !(!m_ov || ordy)) ok = 0;
  endtask

  task automatic model_reset();
    m_ov = 0; m_type = 0; m_data = '0; m_idx = '0;
    m_gid = 0; m_rd = 0; m_wr = 0; m_starve = 0;
  endtask

  task automatic model_update();
    bit ok, w, aw;
    int g;
    if (rst) begin
      model_reset();
    end else begin
      m_pick(ok, g, w, aw);
      if (ok) begin
        if (w) begin
          m_starve = 0;
          m_wr = (g + 1) % N;
        end else begin
          if (aw && m_starve < 15) m_starve++;
          m_rd = (g + 1) % N;
        end
        m_ov = 1; m_type = pt[g]; m_data = pd[g]; m_idx = pi[g]; m_gid = g;
        pv[g] = 0;
      end else if (ordy) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic model_check();
    bit ok, w, aw;
    int g;
    logic [N-1:0] e;
    m_pick(ok, g, w, aw);
    e = '0;
    if (ok) e[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(e));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_type", 64'(bus.out_type), 64'(m_type));
    chk("out_data", 64'(bus.out_data), 64'(m_data));
    chk("out_index", 64'(bus.out_index), 64'(m_idx));
    chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_starve));
    chk("rd_ptr", 64'(dut.rd_ptr), 64'(m_rd));
    chk("wr_ptr", 64'(dut.wr_ptr), 64'(m_wr));
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_type[i]  = pt[i];
      bus.req_data[i*DW +: DW] = pd[i];
      bus.req_index[i*IW +: IW] = pi[i];
    end
    bus.out_ready = ordy;
  endtask

  task automatic settle();
    drive_bus();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pt[i] = 0; pd[i] = DW'(32'h100 + i); pi[i] = IW'(i);
    end
    settle();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  rd_grants;
    bit  got_w;

    rst = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pt[i] = 0; pd[i] = DW'(32'h100 + i); pi[i] = IW'(i);
    end
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state, round-robin reads, then writes only
    vecs.push_back('{1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 0, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 1, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 2, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 3, 0});
    vecs.push_back('{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0});
    vecs.push_back('{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0});
    vecs.push_back('{0, 4'b0110, 4'b0110, 1, 4'b0010, 0, 0, 0});
    vecs.push_back('{0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 1});
    vecs.push_back('{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 1});
    vecs.push_back('{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 1});

    foreach (vecs[v]) begin
      rst = vecs[v].rst;
      ordy = vecs[v].ordy;
      for (int i = 0; i < N; i++) begin
        pv[i] = vecs[v].valid[i];
        pt[i] = vecs[v].typ[i];
      end
      settle();
      chk("tbl_ready", 64'(bus.req_ready), 64'(vecs[v].exp_ready));
      chk("tbl_out_valid", 64'(bus.out_valid), 64'(vecs[v].exp_ov));
      chk("tbl_grant_id", 64'(bus.grant_id), 64'(vecs[v].exp_gid));
      chk("tbl_out_type", 64'(bus.out_type), 64'(vecs[v].exp_type));
      advance();
    end

    // single read with latency of one cycle
    do_reset();
    ordy = 1; pv[2] = 1; pt[2] = 0; pd[2] = 32'hA5; pi[2] = 6'd5;
    settle();
    chk("single_ready", 64'(bus.req_ready), 64'h4);
    advance();
    settle();
    chk("single_valid", 64'(bus.out_valid), 64'h1);
    chk("single_data", 64'(bus.out_data), 64'hA5);
    chk("single_index", 64'(bus.out_index), 64'h5);
    chk("single_gid", 64'(bus.grant_id), 64'h2);
    advance();
    settle();
    chk("single_empty", 64'(bus.out_valid), 64'h0);
    advance();

    // starvation: continuous reads on 0/1 against one write on 3
    do_reset();
    ordy = 1; pv[0] = 1; pv[1] = 1; pv[3] = 1; pt[3] = 1; pi[3] = 6'd3;
    rd_grants = 0; got_w = 0;
    for (int c = 0; c < 12 && !got_w; c++) begin
      settle();
      if (bus.req_ready[3]) got_w = 1;
      else if (|bus.req_ready[1:0]) rd_grants++;
      advance();
      if (!got_w) begin pv[0] = 1; pv[1] = 1; end
    end
    chk("starve_write_granted", 64'(got_w), 64'h1);
    chk("starve_read_grants", 64'(rd_grants), 64'd4);
    settle();
    chk("starve_cleared", 64'(dut.starve_cnt), 64'h0);
    chk("starve_out_type", 64'(bus.out_type), 64'h1);
    chk("starve_gid", 64'(bus.grant_id), 64'h3);
    chk("starve_index", 64'(bus.out_index), 64'h3);
    advance();

    // backpressure holds the output and blocks acceptance
    do_reset();
    ordy = 1; pv[1] = 1;
    settle();
    advance();
    pv[0] = 1; ordy = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("bp_ready", 64'(bus.req_ready), 64'h0);
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_index", 64'(bus.out_index), 64'h1);
      advance();
    end
    ordy = 1;
    settle();
    chk("bp_release_ready", 64'(bus.req_ready), 64'h1);
    advance();
    settle();
    chk("bp_new_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_new_index", 64'(bus.out_index), 64'h0);
    chk("bp_new_gid", 64'(bus.grant_id), 64'h0);
    advance();

    // reset while FULL discards the held completion
    do_reset();
    ordy = 0; pv[2] = 1; pi[2] = 6'd7;
    settle();
    advance();
    pv[3] = 1; pt[3] = 0; rst = 1;
    settle();
    chk("rm_ready_in_rst", 64'(bus.req_ready), 64'h0);
    chk("rm_full_index", 64'(bus.out_index), 64'h7);
    advance();
    rst = 0;
    settle();
    chk("rm_valid", 64'(bus.out_valid), 64'h0);
    chk("rm_rd_ptr", 64'(dut.rd_ptr), 64'h0);
    chk("rm_wr_ptr", 64'(dut.wr_ptr), 64'h0);
    chk("rm_ready", 64'(bus.req_ready), 64'h8);
    advance();
    settle();
    chk("rm_gid", 64'(bus.grant_id), 64'h3);
    advance();

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom % 64 == 0);
      ordy = ($urandom % 100 < 70);
      settle();
      advance();
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 100 < 40)) begin
          pv[i] = 1; pt[i] = 1'($urandom % 2); pd[i] = $urandom; pi[i] = IW'($urandom);
        end else if (pv[i] && ($urandom % 100 < 3)) begin
          pv[i] = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/return_arbiter.md
# return_arbiter

Shares the returner's single completion input between NUM_REQ bank completion ports in the TXN controller front end. It picks one pending completion (read data or write ack) per cycle and registers it into a one-entry output stage that drives the returner. Reads have priority over writes, with a starvation counter so writes always progress. Selection among same-class requesters is round-robin.

## Interface
- NUM_REQ, 4, number of completion requesters (2..8)
- DATA_W, 32, completion data width
- IDX_W, 6, transaction index width
- STARVE_MAX, 4, consecutive read grants tolerated while a write waits (1..15)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  completion pending per requester
- req_type  in  NUM_REQ  0 = read, 1 = write
- req_data  in  NUM_REQ*DATA_W  per-requester data, requester i at bits [i*DATA_W +: DATA_W]
- req_index  in  NUM_REQ*IDX_W  per-requester transaction index, same packing
- req_ready  out  NUM_REQ  one-hot (or zero) accept strobe, combinational
- out_valid  out  1  output stage holds a completion
- out_type  out  1  type of held completion
- out_data  out  DATA_W  data of held completion
- out_index  out  IDX_W  index of held completion
- out_ready  in  1  returner consumes the held completion this cycle
- grant_id  out  $clog2(NUM_REQ)  requester that loaded the current output

## Operation
- Acceptance: requester i is transferred when req_valid[i] & req_ready[i]. The requester must hold type/data/index stable while it is valid and not yet accepted.
- can_load = !out_valid | out_ready. If can_load is low, all req_ready are 0.
- Read candidates: valid requesters with req_type = 0. Write candidates: valid requesters with req_type = 1.
- Class select:
  - writes if write_force is set and a write candidate exists;
  - else reads if any read candidate exists;
  - else writes.
- Within the selected class, grant the first candidate at or after that class's pointer, wrapping modulo NUM_REQ. There are separate rd_ptr and wr_ptr.
- On acceptance of requester g, the class pointer becomes (g+1) mod NUM_REQ. The other pointer is unchanged.
- Starvation counter starve_cnt (4 bits):
  - a read is accepted while any write candidate is valid: increment, saturating;
  - a write is accepted: clear to 0;
  - otherwise: hold.
  - write_force = (starve_cnt >= STARVE_MAX).
- Output stage states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
  - EMPTY -> FULL on acceptance.
  - FULL & out_ready & no acceptance -> EMPTY.
  - FULL & out_ready & acceptance -> FULL with the new contents (back-to-back).
  - FULL & !out_ready -> hold all out_* and grant_id.

## Timing
- Reset values: out_valid 0, out_type 0, out_data 0, out_index 0, grant_id 0, rd_ptr 0, wr_ptr 0, starve_cnt 0. req_ready is 0 during rst.
- Latency: acceptance in cycle N gives out_valid with that completion in cycle N+1.
- Throughput: 1 completion per cycle while out_ready stays high.
- The output stage updates out_* only on acceptance; it never changes them while FULL without out_ready.
- rst asserted mid-operation discards the held completion and any pending grant. Requesters keep req_valid and are re-arbitrated from pointer 0 after rst deasserts.
- Same-cycle events:
  - out_ready together with a new acceptance keeps out_valid = 1 with the new data.
  - A requester dropping req_valid without being accepted is legal; arbitration is recomputed every cycle.
- Pointer wrap: a grant to requester NUM_REQ-1 sets the pointer to 0.

## Test plan
- Single read: req_valid[2] = 1, type 0, data 0xA5, index 5, out_ready = 1 -> req_ready[2] = 1 in cycle N; out_valid = 1, out_data = 0xA5, out_index = 5, grant_id = 2 in cycle N+1; out_valid = 0 in N+2.
- Round-robin: all 4 requesters hold reads, out_ready = 1 -> grants 0, 1, 2, 3, 0 on consecutive cycles, one completion per cycle.
- Starvation: requesters 0 and 1 hold continuous reads, requester 3 holds one write (index 3), STARVE_MAX = 4 -> exactly 4 read grants, then the write is granted; starve_cnt returns to 0.
- Backpressure: out_ready = 0 with output FULL (index 1) and requester 0 valid -> req_ready = 0 and out_* held for 10 cycles. When out_ready rises, the index 1 completion is consumed and requester 0's completion appears the next cycle.
- Reset mid-stream: rst pulsed while FULL with index 7 -> next cycle out_valid = 0 and pointers are 0. After rst falls, a valid requester 3 read is granted with grant_id = 3.
- Mixed types, no reads pending: writes on requesters 1 and 2 with indices 0 and 4 -> grants 1 then 2, out_type = 1 for both.
